// File: rtl/prewish_db_scheduler_if.sv
// Bundle between the debounce scheduler and its debouncer bank / event consumer.
// Poll port: one-hot o_poll_stb request, channel answers on i_resp_stb with i_resp_dat.
// Event port: o_evt_stb is valid, i_evt_ack is ready; transfer when both are 1 in a cycle,
// and o_evt_ch/o_evt_dat hold steady while o_evt_stb=1 without ack.
interface prewish_db_scheduler_if #(
   parameter int N_CH = 4
);
   logic                i_enable;
   logic                o_dbtick;
   logic [N_CH-1:0]     o_poll_stb;
   logic [7:0]          o_poll_dat;
   logic [N_CH-1:0]     i_resp_stb;
   logic [8*N_CH-1:0]   i_resp_dat;
   logic                o_evt_stb;
   logic [2:0]          o_evt_ch;
   logic [7:0]          o_evt_dat;
   logic                i_evt_ack;
   logic                o_timeout_err;
   logic                o_overrun;
   logic [2:0]          o_dbg_state;

   modport master (
      input  i_enable, i_resp_stb, i_resp_dat, i_evt_ack,
      output o_dbtick, o_poll_stb, o_poll_dat, o_evt_stb, o_evt_ch, o_evt_dat,
             o_timeout_err, o_overrun, o_dbg_state
   );

   modport slave (
      output i_enable, i_resp_stb, i_resp_dat, i_evt_ack,
      input  o_dbtick, o_poll_stb, o_poll_dat, o_evt_stb, o_evt_ch, o_evt_dat,
             o_timeout_err, o_overrun, o_dbg_state
   );
endinterface

// File: rtl/prewish_db_scheduler.sv
// Common debounce tick generator plus round-robin poller for a bank of debouncers;
// forwards only changed channel status bytes to a single event consumer.
module prewish_db_scheduler #(
   parameter int          N_CH      = 4,
   parameter int          TICK_BITS = 7,
   parameter int          TIMEOUT   = 15,
   parameter logic [7:0]  POLL_CMD  = 8'h01
) (
   input logic                    clk,
   input logic                    reset,
   prewish_db_scheduler_if.master bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STROBE  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_COMPARE = 3'd3;
   localparam logic [2:0] S_NEXT    = 3'd4;

   // o_dbtick is registered, so it is raised from the count one below all-ones.
   localparam logic [TICK_BITS-1:0] TICK_PRE  = TICK_BITS'((2 ** TICK_BITS) - 2);
   localparam logic [7:0]           TIMEOUT_V = 8'(TIMEOUT);
   localparam logic [2:0]           LAST_CH   = 3'(N_CH - 1);

   logic [TICK_BITS-1:0] tick_cnt;
   logic                 dbtick_q;
   logic [2:0]           state;
   logic [2:0]           ch;
   logic [7:0]           wait_cnt;
   logic [7:0]           cap;
   logic [7:0]           last_q [N_CH];
   logic [N_CH-1:0]      poll_stb_q;
   logic [7:0]           poll_dat_q;
   logic                 evt_stb_q;
   logic [2:0]           evt_ch_q;
   logic [7:0]           evt_dat_q;
   logic                 timeout_err_q;
   logic                 overrun_q;

   logic                 resp_hit;
   logic [7:0]           resp_byte;
   logic [7:0]           last_sel;
   logic [N_CH-1:0]      stb_first;
   logic [N_CH-1:0]      stb_next;
   logic [2:0]           ch_inc;
   logic                 evt_free;

   assign ch_inc   = ch + 3'd1;
   assign evt_free = !evt_stb_q || bus.i_evt_ack;

   // Channel-indexed views built by loop so the 3-bit index never over-selects.
   always_comb begin
      resp_hit  = 1'b0;
      resp_byte = 8'h00;
      last_sel  = 8'h00;
      stb_first = '0;
      stb_next  = '0;
      stb_first[0] = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         if (ch == 3'(k)) begin
            resp_hit  = bus.i_resp_stb[k];
            resp_byte = bus.i_resp_dat[8*k +: 8];
            last_sel  = last_q[k];
         end
         if (ch_inc == 3'(k)) stb_next[k] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt      <= '0;
         dbtick_q      <= 1'b0;
         state         <= S_IDLE;
         ch            <= 3'd0;
         wait_cnt      <= 8'd0;
         cap           <= 8'h00;
         poll_stb_q    <= '0;
         poll_dat_q    <= 8'h00;
         evt_stb_q     <= 1'b0;
         evt_ch_q      <= 3'd0;
         evt_dat_q     <= 8'h00;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
         for (int k = 0; k < N_CH; k++) last_q[k] <= 8'h00;
      end else begin
         tick_cnt   <= tick_cnt + 1'b1;
         dbtick_q   <= (tick_cnt == TICK_PRE);
         poll_stb_q <= '0;
         poll_dat_q <= 8'h00;
         if (evt_stb_q && bus.i_evt_ack) evt_stb_q <= 1'b0;
         // A tick during a round is dropped, never queued.
         if (dbtick_q && state != S_IDLE) overrun_q <= 1'b1;

         case (state)
            S_IDLE: begin
               ch <= 3'd0;
               if (dbtick_q && bus.i_enable) begin
                  state      <= S_STROBE;
                  poll_stb_q <= stb_first;
                  poll_dat_q <= POLL_CMD;
               end
            end
            S_STROBE: begin
               wait_cnt <= 8'd0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (resp_hit) begin
                  cap   <= resp_byte;
                  state <= S_COMPARE;
               end else if (wait_cnt == TIMEOUT_V) begin
                  timeout_err_q <= 1'b1;
                  state         <= S_NEXT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_COMPARE: begin
               if (cap == last_sel) begin
                  state <= S_NEXT;
               end else if (evt_free) begin
                  evt_stb_q <= 1'b1;
                  evt_ch_q  <= ch;
                  evt_dat_q <= cap;
                  for (int k = 0; k < N_CH; k++)
                     if (ch == 3'(k)) last_q[k] <= cap;
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (ch == LAST_CH) begin
                  ch    <= 3'd0;
                  state <= S_IDLE;
               end else begin
                  ch         <= ch_inc;
                  poll_stb_q <= stb_next;
                  poll_dat_q <= POLL_CMD;
                  state      <= S_STROBE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_dbtick      = dbtick_q;
   assign bus.o_poll_stb    = poll_stb_q;
   assign bus.o_poll_dat    = poll_dat_q;
   assign bus.o_evt_stb     = evt_stb_q;
   assign bus.o_evt_ch      = evt_ch_q;
   assign bus.o_evt_dat     = evt_dat_q;
   assign bus.o_timeout_err = timeout_err_q;
   assign bus.o_overrun     = overrun_q;
   assign bus.o_dbg_state   = state;
endmodule

// File: tb/tb_prewish_db_scheduler.sv
// Directed bench for prewish_db_scheduler: round timing table, event scoreboard,
// timeout, disable, stall/overrun and mid-round reset sequences.
module tb_prewish_db_scheduler;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STROBE  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_COMPARE = 3'd3;
   localparam logic [2:0] S_NEXT    = 3'd4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   prewish_db_scheduler_if #(.N_CH(4)) bus ();

   prewish_db_scheduler #(.N_CH(4), .TICK_BITS(7), .TIMEOUT(15), .POLL_CMD(8'h01)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];
   logic [3:0]  resp_en = 4'hF;
   logic [7:0]  resp_val [4];

   typedef struct {
      int         off;
      logic [3:0] stb;
      logic [7:0] dat;
      logic [2:0] st;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!bus.o_dbtick && n < 300);
      if (!bus.o_dbtick) chk("tick_wait_bound", 0, 1);
   endtask

   // Debouncer model: answers in the first WAIT cycle after its strobe.
   initial begin
      logic [3:0] pend;
      pend = '0;
      bus.i_resp_stb = '0;
      bus.i_resp_dat = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.i_resp_stb = pend;
         pend = '0;
         for (int k = 0; k < 4; k++) begin
            if (bus.o_poll_stb[k] && resp_en[k]) pend[k] = 1'b1;
            bus.i_resp_dat[8*k +: 8] = resp_val[k];
         end
      end
   end

   // Event scoreboard: every accepted event must match the head of exp_q.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (!reset && bus.o_evt_stb && bus.i_evt_ack) begin
            if (exp_q.size() == 0) begin
               chk("evt_unexpected", {21'd0, bus.o_evt_ch, bus.o_evt_dat}, 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("evt_data", {21'd0, bus.o_evt_ch, bus.o_evt_dat}, {21'd0, e});
            end
         end
      end
   end

   initial begin
      int n;
      int cur;
      logic seen;
      for (int k = 0; k < 4; k++) resp_val[k] = 8'h00;
      bus.i_enable  = 1'b1;
      bus.i_evt_ack = 1'b1;

      tbl[0] = '{1,  4'b0001, 8'h01, S_STROBE};
      tbl[1] = '{2,  4'b0000, 8'h00, S_WAIT};
      tbl[2] = '{3,  4'b0000, 8'h00, S_COMPARE};
      tbl[3] = '{4,  4'b0000, 8'h00, S_NEXT};
      tbl[4] = '{5,  4'b0010, 8'h01, S_STROBE};
      tbl[5] = '{8,  4'b0000, 8'h00, S_NEXT};
      tbl[6] = '{9,  4'b0100, 8'h01, S_STROBE};
      tbl[7] = '{13, 4'b1000, 8'h01, S_STROBE};
      tbl[8] = '{16, 4'b0000, 8'h00, S_NEXT};
      tbl[9] = '{17, 4'b0000, 8'h00, S_IDLE};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_dbtick", bus.o_dbtick, 0);
      chk("rst_poll_stb", bus.o_poll_stb, 0);
      chk("rst_poll_dat", bus.o_poll_dat, 0);
      chk("rst_evt_stb", bus.o_evt_stb, 0);
      chk("rst_evt_ch", bus.o_evt_ch, 0);
      chk("rst_evt_dat", bus.o_evt_dat, 0);
      chk("rst_timeout", bus.o_timeout_err, 0);
      chk("rst_overrun", bus.o_overrun, 0);
      chk("rst_state", bus.o_dbg_state, S_IDLE);

      // First tick on the 128th cycle
      step(126);
      chk("tick_early", bus.o_dbtick, 0);
      step(1);
      chk("tick_first", bus.o_dbtick, 1);

      // Quiet round, table driven
      cur = 0;
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].off - cur);
         cur = tbl[i].off;
         chk($sformatf("r1_stb_%0d", tbl[i].off), bus.o_poll_stb, tbl[i].stb);
         chk($sformatf("r1_dat_%0d", tbl[i].off), bus.o_poll_dat, tbl[i].dat);
         chk($sformatf("r1_st_%0d", tbl[i].off), bus.o_dbg_state, tbl[i].st);
      end
      chk("r1_no_evt", bus.o_evt_stb, 0);
      chk("r1_flags", {bus.o_timeout_err, bus.o_overrun}, 0);

      // Channel 2 changes to 05
      resp_val[2] = 8'h05;
      exp_q.push_back({3'd2, 8'h05});
      wait_tick(n);
      chk("r2_period", n, 128 - 17);
      step(11);
      chk("r2_evt_pre", bus.o_evt_stb, 0);
      step(1);
      chk("r2_evt_stb", bus.o_evt_stb, 1);
      chk("r2_evt_ch", bus.o_evt_ch, 2);
      chk("r2_evt_dat", bus.o_evt_dat, 8'h05);
      step(1);
      chk("r2_evt_clr", bus.o_evt_stb, 0);

      // Channel 1 silent: timeout, round continues
      resp_en[1]  = 1'b0;
      resp_val[1] = 8'hAA;
      wait_tick(n);
      step(21);
      chk("to_pre_err", bus.o_timeout_err, 0);
      chk("to_pre_st", bus.o_dbg_state, S_WAIT);
      step(1);
      chk("to_err", bus.o_timeout_err, 1);
      chk("to_st", bus.o_dbg_state, S_NEXT);
      step(1);
      chk("to_ch2_stb", bus.o_poll_stb, 4'b0100);
      step(4);
      chk("to_ch3_stb", bus.o_poll_stb, 4'b1000);
      step(4);
      chk("to_idle", bus.o_dbg_state, S_IDLE);
      resp_val[1] = 8'h00;
      resp_en[1]  = 1'b1;

      // Disabled: ticks keep coming, no polling, no overrun
      bus.i_enable = 1'b0;
      wait_tick(n);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.o_poll_stb != 0 || bus.o_dbg_state != S_IDLE) seen = 1'b1;
      end
      chk("dis_no_poll", seen, 0);
      chk("dis_overrun", bus.o_overrun, 0);
      wait_tick(n);
      chk("dis_tick_period", n + 20, 128);
      step(1);
      bus.i_enable = 1'b1;

      // Ack held low: ch0 event held, ch1 stalls, tick during stall
      bus.i_evt_ack = 1'b0;
      resp_val[0] = 8'h11;
      resp_val[1] = 8'h22;
      exp_q.push_back({3'd0, 8'h11});
      exp_q.push_back({3'd1, 8'h22});
      wait_tick(n);
      step(4);
      chk("st_evt0_stb", bus.o_evt_stb, 1);
      chk("st_evt0_ch", bus.o_evt_ch, 0);
      step(6);
      chk("st_stall_st", bus.o_dbg_state, S_COMPARE);
      chk("st_hold_dat", bus.o_evt_dat, 8'h11);
      step(118);
      chk("st_tick", bus.o_dbtick, 1);
      chk("st_ovr_pre", bus.o_overrun, 0);
      step(1);
      chk("st_overrun", bus.o_overrun, 1);
      chk("st_still_ch0", bus.o_evt_ch, 0);
      bus.i_evt_ack = 1'b1;
      step(1);
      chk("st_evt1_stb", bus.o_evt_stb, 1);
      chk("st_evt1_ch", bus.o_evt_ch, 1);
      chk("st_evt1_dat", bus.o_evt_dat, 8'h22);
      chk("st_next", bus.o_dbg_state, S_NEXT);
      step(1);
      chk("st_evt_clr", bus.o_evt_stb, 0);

      // Reset during WAIT on channel 3 with an event pending
      bus.i_evt_ack = 1'b0;
      resp_en[3]  = 1'b0;
      resp_val[0] = 8'h33;
      wait_tick(n);
      step(4);
      chk("mr_evt_pend", bus.o_evt_stb, 1);
      step(12);
      chk("mr_wait", bus.o_dbg_state, S_WAIT);
      reset = 1'b1;
      step(1);
      chk("mr_rst_vals", {bus.o_dbtick, bus.o_poll_stb, bus.o_poll_dat, bus.o_evt_stb,
                          bus.o_evt_ch, bus.o_evt_dat, bus.o_timeout_err, bus.o_overrun}, 0);
      chk("mr_rst_state", bus.o_dbg_state, S_IDLE);
      reset = 1'b0;
      resp_en[3]  = 1'b1;
      bus.i_evt_ack = 1'b1;
      exp_q.push_back({3'd0, 8'h33});
      exp_q.push_back({3'd1, 8'h22});
      exp_q.push_back({3'd2, 8'h05});
      wait_tick(n);
      chk("mr_tick_period", n, 127);
      step(1);
      chk("mr_restart_ch0", bus.o_poll_stb, 4'b0001);
      step(20);
      chk("mr_round_done", bus.o_dbg_state, S_IDLE);
      chk("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prewish_db_scheduler.md
# prewish_db_scheduler

Sequencer and shared-bus controller for a bank of `prewish_debounce` channels. It generates the common debounce tick and polls each debouncer over its STB/DAT student port in round-robin order once per tick. It keeps the last status byte per channel and forwards only changed statuses to one consumer through a valid/ack event port. It replaces per-channel polling logic and per-channel clock dividers in the top level.

## Interface
Parameters:
- N_CH, 4, number of debouncer channels (1..8)
- TICK_BITS, 7, tick period = 2^TICK_BITS clk cycles
- TIMEOUT, 15, max clk cycles to wait for a channel response (1..255)
- POLL_CMD, 8'h01, command byte driven on o_poll_dat

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- i_enable  in  1  1 = polling rounds allowed; tick counter runs regardless
- o_dbtick  out  1  one-cycle pulse every 2^TICK_BITS cycles; drives debouncer i_dbclock
- o_poll_stb  out  N_CH  one-hot poll strobe, bit k to channel k STB_I
- o_poll_dat  out  8  POLL_CMD while any o_poll_stb bit is high, else 8'h00
- i_resp_stb  in  N_CH  channel k STB_O
- i_resp_dat  in  8*N_CH  channel k DAT_O at bits [8k+7:8k]
- o_evt_stb  out  1  event valid, held until acked
- o_evt_ch  out  3  channel index of event
- o_evt_dat  out  8  new status byte of event
- i_evt_ack  in  1  consumer accepts event in a cycle where o_evt_stb=1
- o_timeout_err  out  1  sticky: some channel missed TIMEOUT
- o_overrun  out  1  sticky: tick arrived while a round was in progress

## Operation
- Tick counter: TICK_BITS wide, free-running from 0 after reset. o_dbtick=1 in the cycle where the counter equals all-ones. Wraps to 0.
- States: IDLE, STROBE, WAIT, COMPARE, NEXT. Channel index ch is 3 bits.
- IDLE: ch=0. On o_dbtick=1 with i_enable=1, go to STROBE. A tick with i_enable=0 is ignored and is not an overrun.
- STROBE: o_poll_stb[ch]=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
- WAIT: if i_resp_stb[ch]=1, capture i_resp_dat[ch] and go to COMPARE. Otherwise increment the wait counter. When the counter reaches TIMEOUT, set o_timeout_err and go to NEXT with last[ch] unchanged. Responses from other channels, and responses in any other state, are ignored.
- COMPARE: if the captured byte equals last[ch], go to NEXT. If it differs and no event is pending (o_evt_stb=0, or o_evt_stb=1 with i_evt_ack=1 this cycle): load o_evt_ch=ch and o_evt_dat=captured byte, set last[ch]=captured byte, go to NEXT. If it differs and an event is pending without ack: stay in COMPARE (stall).
- NEXT: if ch==N_CH-1, go to IDLE. Else increment ch and go to STROBE.
- Tick seen in any state other than IDLE: set o_overrun and drop the tick. It does not queue.
- Event port: o_evt_stb, o_evt_ch and o_evt_dat are held stable while unacked. An ack clears o_evt_stb the next cycle unless a new event loads in the same cycle, in which case o_evt_stb stays 1 with the new data.
- Sticky flags are cleared only by reset.

## Timing
- Reset values: o_dbtick=0, o_poll_stb=0, o_poll_dat=8'h00, o_evt_stb=0, o_evt_ch=0, o_evt_dat=8'h00, o_timeout_err=0, o_overrun=0. Also: state=IDLE, ch=0, all last[k]=8'h00, tick counter=0.
- First o_dbtick fires on the 2^TICK_BITS-th cycle after reset deasserts.
- Tick at cycle T: o_poll_stb[0] high at T+1, WAIT begins at T+2.
- Response sampled at cycle R (in WAIT): COMPARE at R+1, o_evt_stb=1 at R+2 if the byte changed.
- Channel with same-cycle response: 4 cycles per channel (STROBE, WAIT, COMPARE, NEXT).
- Timed-out channel: 3+TIMEOUT cycles.
- Reset mid-round: everything returns to reset values the next cycle. A pending event is discarded and the poll strobe drops.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, all channels return 8'h00 immediately → round every 128 cycles; o_poll_stb bits pulse in order 0001, 0010, 0100, 1000 spaced 4 cycles apart; no events; flags stay 0.
- Channel 2 returns 8'h05 from the second round on, i_evt_ack tied 1 → exactly one event, o_evt_ch=2, o_evt_dat=8'h05, at R+2; no repeat on later rounds.
- Channel 1 never responds, TIMEOUT=15 → o_timeout_err=1 after 15 wait cycles; channels 2 and 3 still polled in the same round; no event for ch 1.
- i_evt_ack held 0, channels 0 and 1 both change → event for ch 0 held; FSM stalls in COMPARE for ch 1. Ack → next cycle shows ch 1 event; o_overrun=1 if a tick lands during the stall.
- i_enable=0 → o_dbtick keeps pulsing, o_poll_stb stays 0, o_overrun stays 0.
- Reset asserted during WAIT on channel 3 with an event pending → all outputs at reset values the next cycle; the first round after release restarts at ch 0.
